// File: rtl/alu_input_sequencer_if.sv
// Bundles the switch/button inputs, the ALU operand/result path and the display outputs
// of the ALU input sequencer. Master is the sequencer; slave is the board/ALU side.
interface alu_input_sequencer_if #(
    parameter int N = 4
);
    logic         btn;
    logic [N-1:0] data_in;
    logic [1:0]   op_in;
    logic [N-1:0] alu_result;
    logic         alu_z;
    logic         alu_c;
    logic         alu_v;
    logic         alu_n;
    logic [N-1:0] SrcA;
    logic [N-1:0] SrcB;
    logic [1:0]   operation;
    logic [N-1:0] result_q;
    logic [3:0]   flags_q;
    logic [2:0]   state_o;
    logic         done;

    modport master (
        input  btn, data_in, op_in, alu_result, alu_z, alu_c, alu_v, alu_n,
        output SrcA, SrcB, operation, result_q, flags_q, state_o, done
    );

    modport slave (
        output btn, data_in, op_in, alu_result, alu_z, alu_c, alu_v, alu_n,
        input  SrcA, SrcB, operation, result_q, flags_q, state_o, done
    );
endinterface

// File: rtl/alu_input_sequencer.sv
// Collects A, B and the opcode over three button presses, runs one ALU execute cycle,
// then holds the captured result and flags for display until the next press.
module alu_input_sequencer #(
    parameter int N = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    alu_input_sequencer_if.master   bus
);
    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    state_t       state_reg;
    state_t       state_next;
    logic [2:0]   sync_reg;
    logic         press;
    logic         load_a;
    logic         load_b;
    logic         load_op;
    logic         capture;
    logic [N-1:0] src_a_reg;
    logic [N-1:0] src_b_reg;
    logic [1:0]   operation_reg;
    logic [N-1:0] result_reg;
    logic [3:0]   flags_reg;

    // sync_reg[0..1] is the two-stage synchronizer, sync_reg[2] the edge-detect delay
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[1:0], bus.btn};
        end
    end

    assign press = sync_reg[1] & ~sync_reg[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_A;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load_a     = 1'b0;
        load_b     = 1'b0;
        load_op    = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            S_A: begin
                if (press) begin
                    load_a     = 1'b1;
                    state_next = S_B;
                end
            end
            S_B: begin
                if (press) begin
                    load_b     = 1'b1;
                    state_next = S_OP;
                end
            end
            S_OP: begin
                if (press) begin
                    load_op    = 1'b1;
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                capture    = 1'b1;
                state_next = S_SHOW;
            end
            S_SHOW: begin
                if (press) begin
                    state_next = S_A;
                end
            end
            default: begin
                state_next = S_A;
            end
        endcase
    end

    // Switches are quasi-static, so they are sampled directly on the load edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_a_reg     <= '0;
            src_b_reg     <= '0;
            operation_reg <= 2'b00;
            result_reg    <= '0;
            flags_reg     <= 4'b0000;
        end else begin
            if (load_a) begin
                src_a_reg <= bus.data_in;
            end
            if (load_b) begin
                src_b_reg <= bus.data_in;
            end
            if (load_op) begin
                operation_reg <= bus.op_in;
            end
            if (capture) begin
                result_reg <= bus.alu_result;
                flags_reg  <= {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
            end
        end
    end

    assign bus.SrcA      = src_a_reg;
    assign bus.SrcB      = src_b_reg;
    assign bus.operation = operation_reg;
    assign bus.result_q  = result_reg;
    assign bus.flags_q   = flags_reg;
    assign bus.state_o   = state_reg;
    assign bus.done      = (state_reg == S_SHOW);
endmodule
